// File: rtl/montgomery_product_pkg.sv
// montgomery_product_pkg: shared defaults, FSM states and operand-length helper
package montgomery_product_pkg;
    localparam int DEF_BIT_LEN     = 64;
    localparam int DEF_COUNT_WIDTH = 5;
    localparam int DEF_WORD_W      = 4;

    typedef enum logic [1:0] {IDLE, CALC, SUB, DONE} state_t;

    // Zero or an out-of-range word count falls back to the full operand width
    function automatic int unsigned active_bits(input int unsigned num_words, input int unsigned bit_len,
                                                input int unsigned word_w);
        return (num_words == 0 || num_words > bit_len / word_w) ? bit_len : num_words * word_w;
    endfunction
endpackage

// File: rtl/montgomery_product_if.sv
// montgomery_product_if: request/operand/result bundle between controller and multiplier
interface montgomery_product_if #(
    parameter int bitLen     = 64,
    parameter int countWidth = 5
);
    logic                  start;
    logic [bitLen-1:0]     A;
    logic [bitLen-1:0]     B;
    logic [bitLen-1:0]     M;
    logic [countWidth-1:0] num_words;
    logic                  stop;
    logic [bitLen:0]       P;

    modport master(output start, A, B, M, num_words, input stop, P);
    modport slave(input start, A, B, M, num_words, output stop, P);
endinterface

// File: rtl/montgomery_product_step.sv
// mon_prod_step: one combinational radix-2 Montgomery iteration
module mon_prod_step
    import montgomery_product_pkg::*;
#(
    parameter int bitLen = DEF_BIT_LEN
) (
    input  logic [bitLen+1:0] i_acc,
    input  logic              i_a_bit,
    input  logic [bitLen-1:0] i_b,
    input  logic [bitLen-1:0] i_m,
    output logic [bitLen+1:0] o_acc
);
    logic [bitLen+1:0] w_sum;
    logic [bitLen+1:0] w_red;

    // Add a_i*B, make the sum even by adding M if needed, then divide by two
    always_comb begin
        w_sum = i_acc + (i_a_bit ? {2'b00, i_b} : '0);
        w_red = w_sum[0] ? w_sum + {2'b00, i_m} : w_sum;
        o_acc = w_red >> 1;
    end
endmodule

// File: rtl/montgomery_product.sv
// montgomery_product: bit-serial Montgomery multiplier P = A*B*2^-N mod M
module montgomery_product
    import montgomery_product_pkg::*;
#(
    parameter int bitLen     = DEF_BIT_LEN,
    parameter int countWidth = DEF_COUNT_WIDTH,
    parameter int WORD_W     = DEF_WORD_W
) (
    input logic                 clk,
    input logic                 rst_n,
    montgomery_product_if.slave bus
);
    localparam int CNT_W = $clog2(bitLen + 1);

    state_t              r_state;
    state_t              w_next;
    logic [bitLen-1:0]   r_a;
    logic [bitLen-1:0]   r_b;
    logic [bitLen-1:0]   r_m;
    logic [CNT_W-1:0]    r_n;
    logic [CNT_W-1:0]    r_i;
    logic [bitLen+1:0]   r_acc;
    logic [bitLen+1:0]   w_acc_next;
    logic [bitLen:0]     r_p;
    logic [bitLen:0]     w_diff;
    logic                w_ge;
    logic                w_last;

    // r_a is shifted right every iteration so bit 0 is always the current a_i
    mon_prod_step #(.bitLen(bitLen)) u_step (
        .i_acc  (r_acc),
        .i_a_bit(r_a[0]),
        .i_b    (r_b),
        .i_m    (r_m),
        .o_acc  (w_acc_next)
    );

    assign w_last   = (r_i == r_n - CNT_W'(1));
    assign w_ge     = (r_acc >= {2'b00, r_m});
    assign w_diff   = r_acc[bitLen:0] - {1'b0, r_m};
    assign bus.stop = (r_state == DONE);
    assign bus.P    = r_p;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic; start is only looked at in IDLE and DONE
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = bus.start ? CALC : IDLE;
            CALC:    w_next = w_last ? SUB : CALC;
            SUB:     w_next = DONE;
            DONE:    w_next = bus.start ? DONE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and final conditional subtraction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_m   <= '0;
            r_n   <= '0;
            r_i   <= '0;
            r_acc <= '0;
            r_p   <= '0;
        end else begin
            unique case (r_state)
                IDLE: if (bus.start) begin
                    r_a   <= bus.A;
                    r_b   <= bus.B;
                    r_m   <= bus.M;
                    r_n   <= CNT_W'(active_bits(32'(bus.num_words), bitLen, WORD_W));
                    r_i   <= '0;
                    r_acc <= '0;
                end
                CALC: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a >> 1;
                    r_i   <= r_i + CNT_W'(1);
                end
                SUB:     r_p <= w_ge ? w_diff : r_acc[bitLen:0];
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_montgomery_product.sv
// tb_montgomery_product: scoreboard bench for the Montgomery multiplier
module tb_montgomery_product;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   reqs = 0;
    int   rises = 0;
    logic stop_d = 1'b0;
    logic [64:0] exp_q[$];

    montgomery_product_if bus();

    montgomery_product dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Count rising edges of stop to confirm one completion per request
    always @(negedge clk) begin
        if (bus.stop && !stop_d) rises++;
        stop_d = bus.stop;
    end

    task automatic check(input string tag, input logic [129:0] got, input logic [129:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reduce the plain product first, then apply 2^-1 mod M n times by modular halving
    function automatic logic [64:0] mont_ref(input logic [63:0] a, input logic [63:0] b,
                                             input logic [63:0] m, input int n);
        logic [129:0] x;
        x = ({66'b0, a} * {66'b0, b}) % {66'b0, m};
        for (int k = 0; k < n; k++) x = x[0] ? (x + {66'b0, m}) >> 1 : x >> 1;
        return x[64:0];
    endfunction

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] m,
                          input logic [4:0] nw, input int n, input logic [64:0] exp, input bit hold);
        int cyc;
        logic [64:0] want;
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.M = m;
        bus.num_words = nw;
        bus.start = 1'b1;
        exp_q.push_back(exp);
        reqs++;
        @(posedge clk);
        #1 bus.A = ~a;
        bus.B = ~b;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
            #1;
        end while (!bus.stop && cyc < 200);
        check("latency", 130'(cyc), 130'(n + 1));
        want = exp_q.pop_front();
        check("P", 130'(bus.P), 130'(want));
        check("p_lt_m", 130'(bus.P < {1'b0, m}), 130'(1));
        if (hold) begin
            repeat (4) begin
                @(negedge clk);
                check("held_stop", 130'(bus.stop), 130'(1));
                check("held_p", 130'(bus.P), 130'(want));
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1 check("idle_stop", 130'(bus.stop), 130'(0));
        check("p_kept", 130'(bus.P), 130'(want));
    endtask

    initial begin
        logic [63:0] ra, rb, rm;
        logic [4:0] rnw;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.M = '0;
        bus.num_words = '0;
        #12;
        check("rst_stop", 130'(bus.stop), 130'(0));
        check("rst_p", 130'(bus.P), 130'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(64'd216, 64'd123, 64'd311, 5'd3, 12, 65'd114, 1'b0);
        run_op(64'd1, 64'd1, 64'd13, 5'd1, 4, 65'd9, 1'b0);
        run_op(64'd0, 64'd123, 64'd311, 5'd0, 64, 65'd0, 1'b0);
        run_op(64'd1, 64'd1, 64'd13, 5'd1, 4, 65'd9, 1'b1);
        run_op(64'd216, 64'd123, 64'd311, 5'd3, 12, 65'd114, 1'b1);
        run_op(64'd216, 64'd123, 64'd311, 5'd3, 12, 65'd114, 1'b0);

        @(negedge clk);
        bus.A = 64'd216;
        bus.B = 64'd123;
        bus.M = 64'd311;
        bus.num_words = 5'd3;
        bus.start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_stop", 130'(bus.stop), 130'(0));
        check("async_p", 130'(bus.P), 130'(0));
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op(64'd216, 64'd123, 64'd311, 5'd3, 12, 65'd114, 1'b0);

        for (int t = 0; t < 8; t++) begin
            rm = {$urandom, $urandom} | 64'h8000_0000_0000_0001;
            ra = {$urandom, $urandom} % rm;
            rb = {$urandom, $urandom} % rm;
            rnw = (t % 3 == 0) ? 5'd0 : (t % 3 == 1) ? 5'd16 : 5'd20;
            run_op(ra, rb, rm, rnw, 64, mont_ref(ra, rb, rm, 64), 1'b0);
        end

        check("stop_once", 130'(rises), 130'(reqs));
        check("sb_empty", 130'(exp_q.size()), 130'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
